// File: rtl/water_heater_controller_pkg.sv
// Shared constants, state encoding and small helpers for the water heater controller.
package water_heater_controller_pkg;

    localparam int TEMP_W = 7;
    localparam int TMO_W  = 24;

    // Temperature selector programme points, shared with the selector block.
    localparam logic [TEMP_W-1:0] TEMP_10 = 7'd10;
    localparam logic [TEMP_W-1:0] TEMP_30 = 7'd30;
    localparam logic [TEMP_W-1:0] TEMP_40 = 7'd40;
    localparam logic [TEMP_W-1:0] TEMP_60 = 7'd60;

    localparam logic [TEMP_W-1:0] COLD_TEMP = TEMP_10;
    localparam logic [TEMP_W-1:0] MAX_TEMP  = TEMP_60;
    localparam logic [TEMP_W-1:0] OVERTEMP  = 7'd70;
    localparam logic [TEMP_W-1:0] HYST      = 7'd2;

    localparam logic [TMO_W-1:0] TIMEOUT_CYCLES_DEF = 24'd10_000_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HEAT  = 2'b01,
        ST_HOLD  = 2'b10,
        ST_FAULT = 2'b11
    } heater_state_e;

    // Limit the requested target to the hottest allowed wash temperature.
    function automatic logic [TEMP_W-1:0] clamp_target(input logic [TEMP_W-1:0] req);
        logic [TEMP_W-1:0] res;
        if (req > MAX_TEMP) begin
            res = MAX_TEMP;
        end else begin
            res = req;
        end
        return res;
    endfunction

    // Re-heat threshold while holding: target - HYST, never wrapping below zero.
    function automatic logic [TEMP_W-1:0] hold_threshold(input logic [TEMP_W-1:0] tgt);
        logic [TEMP_W-1:0] res;
        if (tgt > HYST) begin
            res = tgt - HYST;
        end else begin
            res = 7'd0;
        end
        return res;
    endfunction

endpackage

// File: rtl/water_heater_controller_if.sv
// Sequencer/sensor side bundle of the water heater controller.
interface water_heater_controller_if;
    import water_heater_controller_pkg::*;

    logic              start;
    logic              stop;
    logic [TEMP_W-1:0] target_temperature;
    logic              sensor_valid;
    logic [TEMP_W-1:0] sensor_temp;
    logic              heater_on;
    logic              temp_reached;
    logic              busy;
    logic              fault;

    modport master (
        output start, stop, target_temperature, sensor_valid, sensor_temp,
        input  heater_on, temp_reached, busy, fault
    );

    modport slave (
        input  start, stop, target_temperature, sensor_valid, sensor_temp,
        output heater_on, temp_reached, busy, fault
    );

endinterface

// File: rtl/water_heater_controller_timeout.sv
// Heating watchdog: counts cycles while enabled and flags the last allowed cycle.
module heater_timeout_counter #(
    parameter int               TMO_W    = 24,
    parameter logic [TMO_W-1:0] TC_VALUE = 24'd10_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam logic [TMO_W-1:0] ONE = {{(TMO_W-1){1'b0}}, 1'b1};

    logic [TMO_W-1:0] count_q;
    logic [TMO_W-1:0] count_d;

    // Next count: clear dominates, otherwise advance when enabled.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {TMO_W{1'b0}};
        end else if (enable_i) begin
            count_d = count_q + ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= {TMO_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == (TC_VALUE - ONE));

endmodule

// File: rtl/water_heater_controller.sv
// Water heater controller: latches the wash target on start, heats until the
// sensor reports the target, then holds it with hysteresis; reports status.
module water_heater_controller
    import water_heater_controller_pkg::*;
#(
    parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    water_heater_controller_if.slave  bus
);

    heater_state_e     state_q, state_d;
    logic [TEMP_W-1:0] target_q, target_d;
    logic              heater_on_q, heater_on_d;
    logic              reached_q, reached_d;
    logic              busy_q, busy_d;
    logic              fault_q, fault_d;

    logic [TEMP_W-1:0] clamped_s;
    logic [TEMP_W-1:0] threshold_s;
    logic              overtemp_s;
    logic              hit_target_s;
    logic              below_thr_s;
    logic              tmo_tc_s;
    logic              tmo_clear_s;
    logic              tmo_enable_s;

    assign clamped_s    = clamp_target(bus.target_temperature);
    assign threshold_s  = hold_threshold(target_q);
    assign overtemp_s   = bus.sensor_valid && (bus.sensor_temp > OVERTEMP);
    assign hit_target_s = bus.sensor_valid && (bus.sensor_temp >= target_q);
    assign below_thr_s  = bus.sensor_valid && (bus.sensor_temp < threshold_s);

    // The watchdog runs only while heating and restarts from zero on every exit.
    assign tmo_enable_s = (state_q == ST_HEAT);
    assign tmo_clear_s  = (state_d != ST_HEAT);

    heater_timeout_counter #(
        .TMO_W    (TMO_W),
        .TC_VALUE (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (tmo_clear_s),
        .enable_i (tmo_enable_s),
        .tc_o     (tmo_tc_s)
    );

    // Next state and next registered outputs. An explicit stop always returns
    // to IDLE; otherwise over-temperature beats reach, and reach beats timeout.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        heater_on_d = heater_on_q;
        reached_d   = reached_q;
        busy_d      = busy_q;
        fault_d     = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    target_d = clamped_s;
                    busy_d   = 1'b1;
                    fault_d  = 1'b0;
                    if (clamped_s <= COLD_TEMP) begin
                        state_d     = ST_HOLD;
                        heater_on_d = 1'b0;
                        reached_d   = 1'b1;
                    end else begin
                        state_d     = ST_HEAT;
                        heater_on_d = 1'b1;
                        reached_d   = 1'b0;
                    end
                end else begin
                    state_d     = ST_IDLE;
                    heater_on_d = 1'b0;
                    reached_d   = 1'b0;
                    busy_d      = 1'b0;
                    fault_d     = 1'b0;
                end
            end
            ST_HEAT: begin
                if (bus.stop) begin
                    state_d     = ST_IDLE;
                    heater_on_d = 1'b0;
                    reached_d   = 1'b0;
                    busy_d      = 1'b0;
                    fault_d     = 1'b0;
                end else if (overtemp_s || (!hit_target_s && tmo_tc_s)) begin
                    state_d     = ST_FAULT;
                    heater_on_d = 1'b0;
                    reached_d   = 1'b0;
                    busy_d      = 1'b1;
                    fault_d     = 1'b1;
                end else if (hit_target_s) begin
                    state_d     = ST_HOLD;
                    heater_on_d = 1'b0;
                    reached_d   = 1'b1;
                end else begin
                    state_d     = ST_HEAT;
                    heater_on_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.stop) begin
                    state_d     = ST_IDLE;
                    heater_on_d = 1'b0;
                    reached_d   = 1'b0;
                    busy_d      = 1'b0;
                    fault_d     = 1'b0;
                end else if (overtemp_s) begin
                    state_d     = ST_FAULT;
                    heater_on_d = 1'b0;
                    reached_d   = 1'b0;
                    busy_d      = 1'b1;
                    fault_d     = 1'b1;
                end else if (below_thr_s) begin
                    heater_on_d = 1'b1;
                end else if (hit_target_s) begin
                    heater_on_d = 1'b0;
                end else begin
                    heater_on_d = heater_on_q;
                end
            end
            ST_FAULT: begin
                if (bus.stop) begin
                    state_d     = ST_IDLE;
                    heater_on_d = 1'b0;
                    reached_d   = 1'b0;
                    busy_d      = 1'b0;
                    fault_d     = 1'b0;
                end else begin
                    state_d     = ST_FAULT;
                    heater_on_d = 1'b0;
                    reached_d   = 1'b0;
                    busy_d      = 1'b1;
                    fault_d     = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                heater_on_d = 1'b0;
                reached_d   = 1'b0;
                busy_d      = 1'b0;
                fault_d     = 1'b0;
            end
        endcase
    end

    // State, latched target and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            target_q    <= 7'd0;
            heater_on_q <= 1'b0;
            reached_q   <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            heater_on_q <= heater_on_d;
            reached_q   <= reached_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
        end
    end

    assign bus.heater_on    = heater_on_q;
    assign bus.temp_reached = reached_q;
    assign bus.busy         = busy_q;
    assign bus.fault        = fault_q;

endmodule

// File: tb/tb_water_heater_controller.sv
// Bench for water_heater_controller: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the heating rules.
module tb_water_heater_controller;

    localparam int TMO = 16;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_pass;

    water_heater_controller_if wif();

    water_heater_controller #(
        .TIMEOUT_CYCLES (24'd16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (wif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: mode 0 idle, 1 heating, 2 holding, 3 faulted.
    int m_mode;
    int m_tgt;
    int m_heat_cycles;
    int m_heater;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_tgt = 0; m_heat_cycles = 0; m_heater = 0;
    endtask

    task automatic go_fault();
        m_mode = 3; m_heater = 0;
    endtask

    task automatic model_step(input int st, input int sp, input int tgt, input int sv, input int temp);
        int thr;
        case (m_mode)
            0: begin
                if (st != 0 && sp == 0) begin
                    m_tgt = (tgt > 60) ? 60 : tgt;
                    if (m_tgt <= 10) begin
                        m_mode = 2; m_heater = 0;
                    end else begin
                        m_mode = 1; m_heater = 1; m_heat_cycles = 0;
                    end
                end
            end
            1: begin
                if (sp != 0) begin
                    model_reset();
                end else begin
                    m_heat_cycles++;
                    if (sv != 0 && temp > 70) go_fault();
                    else if (sv != 0 && temp >= m_tgt) begin m_mode = 2; m_heater = 0; end
                    else if (m_heat_cycles >= TMO) go_fault();
                end
            end
            2: begin
                thr = (m_tgt - 2 < 0) ? 0 : m_tgt - 2;
                if (sp != 0) model_reset();
                else if (sv != 0 && temp > 70) go_fault();
                else if (sv != 0 && temp < thr) m_heater = 1;
                else if (sv != 0 && temp >= m_tgt) m_heater = 0;
            end
            default: begin
                if (sp != 0) model_reset();
            end
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".heater_on"}, int'(wif.heater_on), m_heater);
        check_eq({tag, ".temp_reached"}, int'(wif.temp_reached), (m_mode == 2) ? 1 : 0);
        check_eq({tag, ".busy"}, int'(wif.busy), (m_mode != 0) ? 1 : 0);
        check_eq({tag, ".fault"}, int'(wif.fault), (m_mode == 3) ? 1 : 0);
    endtask

    // One clock: drive at the falling edge, step the model, sample 1 ns after the rising edge.
    task automatic cycle(input string tag, input int st, input int sp, input int tgt,
                         input int sv, input int temp);
        @(negedge clk);
        wif.start              = st[0];
        wif.stop               = sp[0];
        wif.target_temperature = tgt[6:0];
        wif.sensor_valid       = sv[0];
        wif.sensor_temp        = temp[6:0];
        model_step(st, sp, tgt, sv, temp);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int st, sp, sv, tgt, temp;
        n_checks = 0;
        n_pass   = 0;
        model_reset();
        reset_n = 1'b0;
        wif.start = 1'b0; wif.stop = 1'b0; wif.target_temperature = 7'd0;
        wif.sensor_valid = 1'b0; wif.sensor_temp = 7'd0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // 1: heat to 40
        cycle("t1_start", 1, 0, 40, 0, 0);
        check_eq("t1_heater_after_start", int'(wif.heater_on), 1);
        cycle("t1_s25", 0, 0, 0, 1, 25);
        cycle("t1_s35", 0, 0, 0, 1, 35);
        check_eq("t1_heater_at_35", int'(wif.heater_on), 1);
        cycle("t1_s40", 0, 0, 0, 1, 40);
        check_eq("t1_reached_at_40", int'(wif.temp_reached), 1);
        // 2: hysteresis around 40
        cycle("t2_s39", 0, 0, 0, 1, 39);
        check_eq("t2_heater_at_39", int'(wif.heater_on), 0);
        cycle("t2_idle_sample", 0, 0, 0, 0, 5);
        cycle("t2_s37", 0, 0, 0, 1, 37);
        check_eq("t2_heater_at_37", int'(wif.heater_on), 1);
        cycle("t2_s40", 0, 0, 0, 1, 40);
        check_eq("t2_heater_at_40", int'(wif.heater_on), 0);
        // 5: over-temperature from HOLD, then start+stop together in IDLE
        cycle("t5_s71", 0, 0, 0, 1, 71);
        check_eq("t5_fault", int'(wif.fault), 1);
        cycle("t5_start_ignored", 1, 0, 30, 0, 0);
        cycle("t5_stop", 0, 1, 0, 0, 0);
        cycle("t5_start_stop", 1, 1, 50, 0, 0);
        check_eq("t5_idle_busy", int'(wif.busy), 0);
        // 3: cold wash
        cycle("t3_start10", 1, 0, 10, 0, 0);
        check_eq("t3_reached", int'(wif.temp_reached), 1);
        cycle("t3_stop", 0, 1, 0, 0, 0);
        // 4: timeout with sensor stuck at 30
        cycle("t4_start60", 1, 0, 100, 0, 0);
        for (int i = 1; i <= TMO; i++) begin
            cycle("t4_heat", 0, 0, 0, 1, 30);
        end
        check_eq("t4_fault_after_16", int'(wif.fault), 1);
        check_eq("t4_heater_off", int'(wif.heater_on), 0);
        cycle("t4_stop", 0, 1, 0, 0, 0);
        check_eq("t4_fault_cleared", int'(wif.fault), 0);
        // 6: async reset mid-HEAT
        cycle("t6_start", 1, 0, 50, 0, 0);
        cycle("t6_heat", 0, 0, 0, 1, 20);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_eq("t6_async_heater", int'(wif.heater_on), 0);
        check_eq("t6_async_busy", int'(wif.busy), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic; stop is kept apart from sensor samples.
        for (int n = 0; n < 3000; n++) begin
            st   = ($urandom_range(0, 7) == 0) ? 1 : 0;
            sv   = ($urandom_range(0, 2) == 0) ? 1 : 0;
            sp   = (sv == 0 && $urandom_range(0, 24) == 0) ? 1 : 0;
            tgt  = $urandom_range(0, 127);
            temp = $urandom_range(0, 75);
            cycle("rand", st, sp, tgt, sv, temp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
